vertex_spi_master: RTL and testbench
====================================

# vertex_spi_master

Host-side SPI transmitter that feeds the GPU's vertex input port. It accepts one vertex (x, y, z, each a signed Q16.16 word) per valid/ready handshake and serializes it as three back-to-back SPI words, x first, MSB first. Each word is framed by its own enable pulse, which is the framing the GPU's SPI slave and three-deep vertex FIFO expect. It sits in the test/host harness or a companion FPGA and drives the GPU's SERIALCLOCK, MOSI and ENABLE pins.

## Interface
- N, 32, bits per SPI word (vertex component width).
- CLK_DIV, 4, i_clk cycles per SCK half-period; legal range ≥1.
- GAP, 8, i_clk cycles with enable low between words; legal range ≥1.
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_vertex  in  3N  {x, y, z}; x in [3N-1:2N], z in [N-1:0].
- i_valid  in  1  vertex offered.
- o_ready  out  1  block idle, will accept; reset 1.
- o_sck  out  1  SPI clock, idle low (mode 0); reset 0.
- o_mosi  out  1  serial data; reset 0.
- o_en  out  1  word frame, active high; reset 0.
- o_busy  out  1  vertex in flight (= ~o_ready); reset 0.
- o_word_done  out  1  one-cycle pulse per finished word; reset 0.
- o_vertex_done  out  1  one-cycle pulse after the third word; reset 0.

## Operation
- States: IDLE, SETUP, SCK_HI, SCK_LO, GAP.
- IDLE: o_ready=1. On i_valid & o_ready, latch i_vertex, clear word index to 0 and go to SETUP. o_ready drops on the next cycle.
- SETUP: o_en=1, o_sck=0, o_mosi=bit N-1 of the current word. Hold for CLK_DIV cycles, then go to SCK_HI.
- SCK_HI: o_sck=1 for CLK_DIV cycles; the slave samples on this rising edge. Exit to SCK_LO.
- SCK_LO: o_sck=0 for CLK_DIV cycles.
  - MOSI advances to the next bit on entry to SCK_LO.
  - After the N-th bit, MOSI holds and the exit goes to GAP with o_en falling.
  - Otherwise exit to SCK_HI.
- GAP: o_en=0, o_mosi=0 for GAP cycles. o_word_done pulses on the first GAP cycle. At the end of GAP:
  - word index < 2: increment and go to SETUP.
  - word index = 2: pulse o_vertex_done, go to IDLE.
- Word order is x, y, z. The receiver shifts words in left, so x lands in its top slice.
- Bit counter is log2(N)+1 bits wide. Phase counter is wide enough for max(CLK_DIV, GAP).
- i_vertex is ignored while busy, and i_valid has no effect there. The latched copy is immune to input changes.

## Timing
- Word time = CLK_DIV·(2N+1) + GAP cycles. With the defaults: 4·65 + 8 = 268 cycles per word, 804 per vertex.
- Latency from handshake cycle to first o_en high is 1 cycle.
- o_ready returns high the cycle after o_vertex_done.
  - A new i_valid may be accepted that same cycle, so vertices can be streamed back-to-back.
  - Between vertices: one IDLE cycle plus the final GAP.
- o_vertex_done coincides with the last cycle of the third GAP. o_word_done for that word comes earlier, on the first GAP cycle.
- Reset asserted mid-word forces all outputs to reset values immediately, asynchronously. The partial word and latched vertex are discarded; the receiver sees o_en fall and must drop its partial word. After release, the first active edge is IDLE.
- CLK_DIV=1, GAP=1 must work: 2N+2 cycles per word.

## Structure
- Shared package (gpu_spi_pkg): state enum, SPI_WORDS_PER_VERTEX=3, default N=32, Q=16.
- Sub-module spi_word_serializer handles one word: SETUP/SCK_HI/SCK_LO/GAP, start/done handshake, N-bit shift register. vertex_spi_master sequences three words and owns valid/ready. Target roughly 200 lines total.

## Test plan
- Reset, then idle: o_ready=1 and all SPI outputs 0 for 100 cycles with i_valid=0.
- Defaults, send {x=0x0001_0000, y=0xFFFF_0000, z=0x0000_8000}.
  - Bench SPI slave model samples on SCK rise and reassembles exactly those three words in order.
  - o_en high 260 cycles per word; o_vertex_done at cycle 804 after the handshake.
- Send alternating 0xAAAA_AAAA / 0x5555_5555 patterns.
  - MOSI changes only while o_sck=0; never an edge in the same cycle as an o_sck rise.
- Hold i_valid high with two queued vertices: the second handshake occurs the cycle o_ready rises. The gap between o_en falling and next o_en rising equals GAP+1 at the vertex boundary and GAP within a vertex.
- Assert i_rst_n low at bit 17 of word y: o_en/o_sck/o_mosi go 0 asynchronously. After release, a new vertex transmits cleanly and the slave model sees exactly three whole words.
- CLK_DIV=1, GAP=1, N=8: 18 cycles per word, and the slave model recovers 0x80/0x01/0xFF correctly.

Source files
------------

// File: rtl/gpu_spi_pkg.sv
// Shared types and constants for the host-to-GPU vertex SPI link.
package gpu_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SCK_HI = 3'd2,
    ST_SCK_LO = 3'd3,
    ST_GAP    = 3'd4
  } spi_state_e;

  localparam int SPI_WORDS_PER_VERTEX = 3;
  localparam int SPI_N_DEFAULT        = 32;
  localparam int SPI_Q                = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_word_serializer.sv
// Sends one N-bit word MSB first as a mode-0 SPI frame, then holds enable low for GAP cycles.
// A start seen in the final gap cycle chains straight into the next word's SETUP.
module spi_word_serializer
  import gpu_spi_pkg::*;
#(
  parameter int N       = SPI_N_DEFAULT,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         last,
  input  logic [N-1:0] word,
  output logic         sck,
  output logic         mosi,
  output logic         en,
  output logic         word_done,
  output logic         done,
  output logic         last_done
);

  localparam int CNT_W = $clog2(max_int(CLK_DIV, GAP) + 1);
  localparam int BIT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(N);

  spi_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0] bit_r, bit_nxt_s;
  logic [N-1:0]     shift_r, shift_nxt_s;
  logic             last_r, last_nxt_s;
  logic             en_nxt_s, sck_nxt_s, mosi_nxt_s, word_done_nxt_s, done_nxt_s;

  // State, phase counter and outputs registered together; outputs come from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_r     <= BIT_ZERO;
      shift_r   <= {N{1'b0}};
      last_r    <= 1'b0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      en        <= 1'b0;
      word_done <= 1'b0;
      done      <= 1'b0;
      last_done <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_r     <= bit_nxt_s;
      shift_r   <= shift_nxt_s;
      last_r    <= last_nxt_s;
      sck       <= sck_nxt_s;
      mosi      <= mosi_nxt_s;
      en        <= en_nxt_s;
      word_done <= word_done_nxt_s;
      done      <= done_nxt_s;
      last_done <= done_nxt_s & last_nxt_s;
    end
  end

  // Phase sequencing; the shift after the final bit is skipped so MOSI holds through the last low phase
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SETUP;
          cnt_nxt_s   = DIV_LOAD;
          bit_nxt_s   = BIT_ZERO;
          shift_nxt_s = word;
          last_nxt_s  = last;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_SCK_HI;
          cnt_nxt_s   = DIV_LOAD;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_SCK_HI: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_SCK_LO;
          cnt_nxt_s   = DIV_LOAD;
          bit_nxt_s   = bit_r + BIT_ONE;
          if (bit_r != BIT_LAST) begin
            shift_nxt_s = {shift_r[N-2:0], 1'b0};
          end else begin
            shift_nxt_s = shift_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_SCK_LO: begin
        if (cnt_r == CNT_ZERO) begin
          if (bit_r == BIT_ALL) begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = GAP_LOAD;
          end else begin
            state_nxt_s = ST_SCK_HI;
            cnt_nxt_s   = DIV_LOAD;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          if (start) begin
            state_nxt_s = ST_SETUP;
            cnt_nxt_s   = DIV_LOAD;
            bit_nxt_s   = BIT_ZERO;
            shift_nxt_s = word;
            last_nxt_s  = last;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    en_nxt_s        = (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SCK_HI) ||
                      (state_nxt_s == ST_SCK_LO);
    sck_nxt_s       = (state_nxt_s == ST_SCK_HI);
    mosi_nxt_s      = en_nxt_s & shift_nxt_s[N-1];
    word_done_nxt_s = (state_nxt_s == ST_GAP) && (state_r != ST_GAP);
    done_nxt_s      = (state_nxt_s == ST_GAP) && (cnt_nxt_s == CNT_ZERO);
  end

endmodule

// File: rtl/vertex_spi_master.sv
// Accepts one {x,y,z} vertex per valid/ready handshake and sends it as three framed SPI words,
// x first. The next word is chained from the serializer's last gap cycle so no idle cycle appears.
module vertex_spi_master
  import gpu_spi_pkg::*;
#(
  parameter int N       = SPI_N_DEFAULT,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [3*N-1:0] i_vertex,
  input  logic           i_valid,
  output logic           o_ready,
  output logic           o_sck,
  output logic           o_mosi,
  output logic           o_en,
  output logic           o_busy,
  output logic           o_word_done,
  output logic           o_vertex_done
);

  localparam logic [1:0] LAST_IDX = 2'(SPI_WORDS_PER_VERTEX - 1);

  logic [3*N-1:0] vertex_r;
  logic [1:0]     word_idx_r;
  logic           ready_r, busy_r;
  logic           accept_s, next_word_s, start_s, last_s, ser_done_s;
  logic [N-1:0]   word_s;

  assign accept_s    = i_valid & ready_r;
  assign next_word_s = ser_done_s & (word_idx_r != LAST_IDX);
  assign start_s     = accept_s | next_word_s;
  assign o_ready     = ready_r;
  assign o_busy      = busy_r;

  // Handshake, vertex latch and word index
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vertex_r   <= {(3*N){1'b0}};
      word_idx_r <= 2'd0;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else if (accept_s) begin
      vertex_r   <= i_vertex;
      word_idx_r <= 2'd0;
      ready_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else if (next_word_s) begin
      word_idx_r <= word_idx_r + 2'd1;
    end else if (o_vertex_done) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= ready_r;
    end
  end

  // Word offered to the serializer: x straight from the input on accept, else the next latched slice
  always_comb begin
    word_s = vertex_r[N-1:0];
    last_s = 1'b0;
    if (accept_s) begin
      word_s = i_vertex[3*N-1:2*N];
      last_s = 1'b0;
    end else begin
      case (word_idx_r)
        2'd0: begin
          word_s = vertex_r[2*N-1:N];
          last_s = 1'b0;
        end
        2'd1: begin
          word_s = vertex_r[N-1:0];
          last_s = 1'b1;
        end
        default: begin
          word_s = vertex_r[N-1:0];
          last_s = 1'b1;
        end
      endcase
    end
  end

  spi_word_serializer #(
    .N       (N),
    .CLK_DIV (CLK_DIV),
    .GAP     (GAP)
  ) u_ser (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .start     (start_s),
    .last      (last_s),
    .word      (word_s),
    .sck       (o_sck),
    .mosi      (o_mosi),
    .en        (o_en),
    .word_done (o_word_done),
    .done      (ser_done_s),
    .last_done (o_vertex_done)
  );

endmodule

// File: tb/tb_vertex_spi_master.sv
// Directed bench: SPI slave models reassemble words and record frame timing for two configurations.
module tb_vertex_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, valid, ready, sck, mosi, en, busy, wdone, vdone;
  logic [95:0] vertex;
  logic        rst_s, valid_s, ready_s, sck_s, mosi_s, en_s, busy_s, wdone_s, vdone_s;
  logic [23:0] vertex_s;

  vertex_spi_master dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vertex(vertex), .i_valid(valid), .o_ready(ready),
    .o_sck(sck), .o_mosi(mosi), .o_en(en), .o_busy(busy), .o_word_done(wdone),
    .o_vertex_done(vdone));

  vertex_spi_master #(.N(8), .CLK_DIV(1), .GAP(1)) dut_s (
    .i_clk(clk), .i_rst_n(rst_s), .i_vertex(vertex_s), .i_valid(valid_s), .o_ready(ready_s),
    .o_sck(sck_s), .o_mosi(mosi_s), .o_en(en_s), .o_busy(busy_s), .o_word_done(wdone_s),
    .o_vertex_done(vdone_s));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave model state for the default-configuration DUT
  int          cyc = 0, nbits = 0, en_run = 0, low_run = 0, edge_viol = 0, wdone_cnt = 0;
  logic        sck_q = 1'b0, mosi_q = 1'b0, en_q = 1'b0, low_valid = 1'b0;
  logic [31:0] sh = 32'd0;
  logic [31:0] words[$];
  int          en_runs[$], low_runs[$], rise_cyc[$], vdone_cyc[$], hs_cyc[$];

  // Slave model state for the small DUT
  int          nbits2 = 0, en_run2 = 0;
  logic        sck_q2 = 1'b0, en_q2 = 1'b0;
  logic [7:0]  sh2 = 8'd0;
  logic [7:0]  words2[$];
  int          en_runs2[$], rise2[$], vdone2[$], hs2[$];

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sck && (mosi !== mosi_q)) edge_viol++;
      if (sck && !sck_q) begin sh = {sh[30:0], mosi}; nbits++; end
      if (en && !en_q) begin
        rise_cyc.push_back(cyc);
        if (low_valid) low_runs.push_back(low_run);
        low_valid = 1'b0;
        en_run = 0;
      end
      if (en) en_run++;
      if (!en && en_q) begin
        en_runs.push_back(en_run);
        if (nbits == 32) words.push_back(sh);
        nbits = 0;
        low_valid = 1'b1;
        low_run = 0;
      end
      if (!en) low_run++;
      if (wdone) wdone_cnt++;
      if (vdone) vdone_cyc.push_back(cyc);
      if (valid && ready) hs_cyc.push_back(cyc);
      sck_q = sck; mosi_q = mosi; en_q = en;
      if (sck_s && !sck_q2) begin sh2 = {sh2[6:0], mosi_s}; nbits2++; end
      if (en_s && !en_q2) begin rise2.push_back(cyc); en_run2 = 0; end
      if (en_s) en_run2++;
      if (!en_s && en_q2) begin
        en_runs2.push_back(en_run2);
        if (nbits2 == 8) words2.push_back(sh2);
        nbits2 = 0;
      end
      if (vdone_s) vdone2.push_back(cyc);
      if (valid_s && ready_s) hs2.push_back(cyc);
      sck_q2 = sck_s; en_q2 = en_s;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] qw(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic int qi(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_mon();
    words.delete(); en_runs.delete(); low_runs.delete(); rise_cyc.delete();
    vdone_cyc.delete(); hs_cyc.delete();
    low_valid = 1'b0; wdone_cnt = 0;
  endtask

  task automatic send_vertex(input logic [95:0] v);
    valid = 1'b1; vertex = v;
    @(posedge clk); #1;
    valid = 1'b0; vertex = 96'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
  endtask

  task automatic wait_vdone(input string tag, input int n);
    int k = 0;
    while (vdone_cyc.size() < n && k < 3000) begin @(posedge clk); #1; k++; end
    check_eq(tag, vdone_cyc.size(), n);
  endtask

  task automatic check_words(input string tag, input logic [31:0] exp[$]);
    check_eq({tag, "_count"}, words.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) check_eq($sformatf("%s_w%0d", tag, i), qw(words, i), exp[i]);
  endtask

  initial begin
    int k, bad;
    logic [31:0] exp_w[$];
    valid = 1'b0; vertex = '0; valid_s = 1'b0; vertex_s = '0; rst_n = 1'b0; rst_s = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_ready", ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_spi", {sck, mosi, en, wdone, vdone}, 5'b0);
    rst_n = 1'b1; rst_s = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || busy || sck || mosi || en || wdone || vdone) bad++;
    end
    check_eq("idle_100", bad, 0);

    // Basic vertex with default timing
    clear_mon();
    send_vertex({32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000});
    check_eq("t2_ready_low", ready, 1'b0);
    check_eq("t2_busy_high", busy, 1'b1);
    wait_vdone("t2_vdone_seen", 1);
    check_eq("t2_ready_back", ready, 1'b1);
    check_eq("t2_busy_back", busy, 1'b0);
    exp_w = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000};
    check_words("t2", exp_w);
    for (int i = 0; i < 3; i++) check_eq($sformatf("t2_en_len%0d", i), qi(en_runs, i), 260);
    check_eq("t2_gap0", qi(low_runs, 0), 8);
    check_eq("t2_gap1", qi(low_runs, 1), 8);
    check_eq("t2_first_en_lat", qi(rise_cyc, 0) - qi(hs_cyc, 0), 1);
    check_eq("t2_vdone_lat", qi(vdone_cyc, 0) - qi(hs_cyc, 0), 804);
    check_eq("t2_word_done_n", wdone_cnt, 3);
    check_eq("t2_vdone_n", vdone_cyc.size(), 1);

    // Alternating patterns and MOSI/SCK edge discipline
    clear_mon();
    send_vertex({32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA});
    wait_vdone("t3_vdone_seen", 1);
    exp_w = '{32'hAAAA_AAAA, 32'h5555_5555, 32'hAAAA_AAAA};
    check_words("t3", exp_w);
    check_eq("t3_mosi_edge_viol", edge_viol, 0);

    // Two vertices streamed with valid held high; input changes while busy must not leak in
    clear_mon();
    valid = 1'b1; vertex = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    k = 0;
    while (hs_cyc.size() < 2 && k < 3000) begin
      @(posedge clk); #1; k++;
      if (hs_cyc.size() == 1) vertex = {32'h4444_4444, 32'h8000_0001, 32'h7FFF_FFFE};
    end
    valid = 1'b0;
    check_eq("t4_hs_n", hs_cyc.size(), 2);
    wait_vdone("t4_vdone_seen", 2);
    check_eq("t4_hs_after_vdone", qi(hs_cyc, 1) - qi(vdone_cyc, 0), 1);
    check_eq("t4_gap_in0", qi(low_runs, 0), 8);
    check_eq("t4_gap_in1", qi(low_runs, 1), 8);
    check_eq("t4_gap_boundary", qi(low_runs, 2), 9);
    check_eq("t4_gap_in3", qi(low_runs, 3), 8);
    exp_w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
              32'h4444_4444, 32'h8000_0001, 32'h7FFF_FFFE};
    check_words("t4", exp_w);

    // Reset in the middle of word y, then a clean vertex
    clear_mon();
    send_vertex({32'h1234_5678, 32'hFFFF_FFFF, 32'h0F0F_0F0F});
    k = 0;
    while (!(words.size() == 1 && nbits == 17) && k < 3000) begin @(posedge clk); #1; k++; end
    check_eq("t5_reach_bit17", nbits, 17);
    check_eq("t5_pre_rst_en", en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_async_spi", {en, sck, mosi}, 3'b000);
    check_eq("t5_async_ready", {ready, busy}, 2'b10);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("t5_idle_after", {ready, en}, 2'b10);
    send_vertex({32'hCAFE_BABE, 32'h0000_0001, 32'h8000_0000});
    wait_vdone("t5_vdone_seen", 1);
    exp_w = '{32'h1234_5678, 32'hCAFE_BABE, 32'h0000_0001, 32'h8000_0000};
    check_words("t5", exp_w);

    // Minimum timing, N=8
    valid_s = 1'b1; vertex_s = {8'h80, 8'h01, 8'hFF};
    @(posedge clk); #1;
    valid_s = 1'b0; vertex_s = 24'h5A5A5A;
    k = 0;
    while (vdone2.size() < 1 && k < 500) begin @(posedge clk); #1; k++; end
    check_eq("t6_vdone_seen", vdone2.size(), 1);
    check_eq("t6_words_n", words2.size(), 3);
    check_eq("t6_w0", (words2.size() > 0) ? words2[0] : 8'h00, 8'h80);
    check_eq("t6_w1", (words2.size() > 1) ? words2[1] : 8'h00, 8'h01);
    check_eq("t6_w2", (words2.size() > 2) ? words2[2] : 8'h00, 8'hFF);
    for (int i = 0; i < 3; i++) check_eq($sformatf("t6_en_len%0d", i), qi(en_runs2, i), 17);
    check_eq("t6_word_period", qi(rise2, 1) - qi(rise2, 0), 18);
    check_eq("t6_vdone_lat", qi(vdone2, 0) - qi(hs2, 0), 54);
    check_eq("t6_ready_back", ready_s, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
